// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input FIFO feeding a start/data/parity/stop
// serialiser with a registered, glitch-free TX line.
module uart_tx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  ready,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic                  TX_out,
  output logic                  busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- input FIFO ----------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head;

  assign ready      = (count_reg != CNT_FULL);
  assign push       = valid_in && ready;
  assign fifo_empty = (count_reg == '0);
  assign head       = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- serialiser ----------------
  state_t                state_reg, state_next;
  logic [BAUD_W-1:0]     baud_reg, baud_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  two_stop_reg, two_stop_next;
  logic                  tx_reg, tx_next;
  logic                  baud_wrap;

  assign baud_wrap = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
      two_stop_reg <= two_stop_next;
      tx_reg       <= tx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_next     = baud_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
    two_stop_next = two_stop_reg;
    pop           = 1'b0;
    tx_next       = 1'b1;

    if (state_reg != IDLE) begin
      baud_next = baud_wrap ? '0 : baud_reg + 1'b1;
    end

    case (state_reg)
      IDLE: pop = !fifo_empty;
      START: begin
        if (baud_wrap) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == BIT_LAST) begin
            bit_next   = '0;
            state_next = par_en_reg ? PARITY : STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          state_next = STOP;
          bit_next   = '0;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (two_stop_reg && (bit_reg == '0)) begin
            bit_next = BIT_W'(1);
          end else begin
            bit_next   = '0;
            state_next = IDLE;
            pop        = !fifo_empty;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Loading a word (from IDLE or straight out of the last stop bit) freezes the frame config
    if (pop) begin
      state_next    = START;
      baud_next     = '0;
      bit_next      = '0;
      shift_next    = head;
      par_en_next   = parity_mode[0] ^ parity_mode[1];
      par_bit_next  = (^head) ^ (parity_mode == 2'b10);
      two_stop_next = two_stop;
    end

    // TX is registered from the next state so the line changes on the same edge as the FSM
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_bit_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign TX_out = tx_reg;
  assign busy   = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: table of single frames, back-to-back, FIFO overflow,
// mid-frame reset and config-freeze sequences; a monitor decodes every frame.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] tx_data;
  logic       ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       TX_out;
  logic       busy;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .tx_data    (tx_data),
    .ready      (ready),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .TX_out     (TX_out),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
    int         exp_len;
    logic       has_par;
    logic       exp_par;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs [6];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called just after a rising edge; returns just after the edge that samples the word
  task automatic send_word(input logic [7:0] d, input logic [1:0] m, input logic t,
                           input logic exp_acc);
    exp_t e;
    valid_in    = 1'b1;
    tx_data     = d;
    parity_mode = m;
    two_stop    = t;
    @(negedge clk);
    chk("ready", {31'd0, ready}, {31'd0, exp_acc});
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (exp_acc) begin
      e.data = d;
      e.mode = m;
      e.two  = t;
      exp_q.push_back(e);
    end
    $display("write %02h mode %0d two %0d expect_accept %0d", d, m, t, exp_acc);
  endtask

  task automatic wait_idle(input int c0, input int exp_cycles, input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy === 1'b1 && guard < 2000);
    chk(name, cyc - c0, exp_cycles);
  endtask

  // Monitor: decodes each frame cycle by cycle against the scoreboard
  initial begin : monitor
    exp_t        e;
    logic [11:0] fb;
    int          nb;
    int          bad;
    logic        bad_val;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && TX_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL frame: start bit with no word queued (cycle %0d)", cyc);
          repeat (CPB) @(negedge clk);
        end else begin
          e  = exp_q.pop_front();
          fb = '0;
          fb[0] = 1'b0;
          for (int k = 0; k < 8; k++) fb[1+k] = e.data[k];
          nb = 9;
          if (e.mode == 2'b01) begin
            fb[nb] = ^e.data;
            nb++;
          end else if (e.mode == 2'b10) begin
            fb[nb] = ~^e.data;
            nb++;
          end
          fb[nb] = 1'b1;
          nb++;
          if (e.two) begin
            fb[nb] = 1'b1;
            nb++;
          end
          bad     = -1;
          bad_val = 1'b0;
          aborted = 1'b0;
          for (int i = 0; i < nb * CPB && !aborted; i++) begin
            if (i > 0) @(negedge clk);
            if (reset === 1'b1) aborted = 1'b1;
            else if (bad < 0 && TX_out !== fb[i/CPB]) begin
              bad     = i;
              bad_val = TX_out;
            end
          end
          if (aborted) begin
            $display("frame %02h aborted by reset", e.data);
          end else begin
            checks++;
            if (bad < 0) begin
              passes++;
              $display("frame %02h mode %0d two %0d received", e.data, e.mode, e.two);
            end else begin
              $display("FAIL frame %02h: sample %0d got %b expected %b", e.data, bad,
                       bad_val, fb[bad/CPB]);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int c0;
    int guard;
    vecs[0] = '{8'h62, 2'b00, 1'b0, 40, 1'b0, 1'b0};
    vecs[1] = '{8'hCC, 2'b01, 1'b0, 44, 1'b1, 1'b0};
    vecs[2] = '{8'hCC, 2'b10, 1'b0, 44, 1'b1, 1'b1};
    vecs[3] = '{8'h01, 2'b01, 1'b1, 48, 1'b1, 1'b1};
    vecs[4] = '{8'hA5, 2'b11, 1'b0, 40, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 2'b10, 1'b1, 48, 1'b1, 1'b1};

    reset = 1'b1; valid_in = 1'b0; tx_data = '0; parity_mode = '0; two_stop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'd0, TX_out}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, ready}, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single frames from the table
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].data, vecs[i].mode, vecs[i].two, 1'b1);
      c0 = cyc;
      @(negedge clk);
      chk("tx_before_start", {31'd0, TX_out}, 1);
      @(negedge clk);
      chk("start_bit", {31'd0, TX_out}, 0);
      guard = 0;
      while (busy === 1'b1 && guard < 1000) begin
        @(negedge clk);
        guard++;
        if (vecs[i].has_par && cyc == c0 + 1 + 9 * CPB)
          chk("parity_bit", {31'd0, TX_out}, {31'd0, vecs[i].exp_par});
      end
      chk("frame_len", cyc - c0 - 1, vecs[i].exp_len);
      chk("idle_line", {31'd0, TX_out}, 1);
      @(posedge clk);
      #1;
    end

    // Back-to-back frames: no idle gap between them
    send_word(8'h11, 2'b00, 1'b0, 1'b1);
    c0 = cyc;
    send_word(8'h22, 2'b00, 1'b0, 1'b1);
    send_word(8'h33, 2'b00, 1'b0, 1'b1);
    wait_idle(c0, 121, "b2b_busy_len");
    @(posedge clk);
    #1;

    // FIFO overflow: sixth word arrives while full and is dropped
    send_word(8'hA1, 2'b00, 1'b0, 1'b1);
    c0 = cyc;
    send_word(8'hA2, 2'b00, 1'b0, 1'b1);
    send_word(8'hA3, 2'b00, 1'b0, 1'b1);
    send_word(8'hA4, 2'b00, 1'b0, 1'b1);
    send_word(8'hA5, 2'b00, 1'b0, 1'b1);
    send_word(8'hA6, 2'b00, 1'b0, 1'b0);
    wait_idle(c0, 201, "overflow_busy_len");
    chk("overflow_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset during data bit 3
    send_word(8'h5A, 2'b00, 1'b0, 1'b1);
    c0 = cyc;
    repeat (18) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_tx", {31'd0, TX_out}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ready", {31'd0, ready}, 1);
    @(posedge clk);
    #1;

    // Config changed mid-frame must not affect the frame in flight
    send_word(8'h96, 2'b01, 1'b0, 1'b1);
    c0 = cyc;
    repeat (10) @(posedge clk);
    #1 parity_mode = 2'b10;
    two_stop = 1'b1;
    wait_idle(c0, 45, "frozen_cfg_len");
    parity_mode = 2'b00;
    two_stop = 1'b0;
    repeat (2) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
